// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic {
        RUN    = 1'b0,
        I_KILL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Fixed-priority stall/flush sequencer for the 5-stage pipeline: D-miss,
// taken branch, wrong-path fetch kill, load-use, I-miss; plus stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ic_ready,
    input  logic             dc_req,
    input  logic             dc_ready,
    input  logic             br_taken,
    input  logic             load_use,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_zero,
    output logic             id_ex_we,
    output logic             id_ex_zero,
    output logic             ex_mem_we,
    output logic             ex_mem_zero,
    output logic             mem_wb_we,
    output logic             mem_wb_zero,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state, state_nxt;
    logic      ds, is;
    logic      flush_inc, stall_inc;

    assign ds = dc_req & ~dc_ready;
    assign is = ~ic_ready;

    always_comb begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_zero  = 1'b0;
        id_ex_we    = 1'b1;
        id_ex_zero  = 1'b0;
        ex_mem_we   = 1'b1;
        ex_mem_zero = 1'b0;
        mem_wb_we   = 1'b1;
        mem_wb_zero = 1'b0;
        flush_inc   = 1'b0;
        state_nxt   = state;

        if (!rst) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
            state_nxt = RUN;
        end else if (ds) begin
            // EX is frozen, so a pending branch/load-use is seen again once the miss clears
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_we    = 1'b0;
            ex_mem_we   = 1'b0;
            mem_wb_zero = 1'b1;
        end else if (br_taken) begin
            if_id_zero = 1'b1;
            id_ex_zero = 1'b1;
            flush_inc  = 1'b1;
            state_nxt  = is ? I_KILL : RUN;
        end else if (state == I_KILL) begin
            // the word returning on ic_ready is the stale fetch; the bubble drops it
            pc_we      = 1'b0;
            if_id_zero = 1'b1;
            if (ic_ready) begin
                state_nxt = RUN;
            end
        end else if (load_use) begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_zero = 1'b1;
        end else if (is) begin
            pc_we      = 1'b0;
            if_id_zero = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign stall_inc = rst & ~pc_we;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl, built with 4-bit counters so saturation is reachable.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_ready, dc_req, dc_ready, br_taken, load_use;
    logic         pc_we, if_id_we, if_id_zero, id_ex_we, id_ex_zero;
    logic         ex_mem_we, ex_mem_zero, mem_wb_we, mem_wb_zero;
    logic [W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ic_ready    (ic_ready),
        .dc_req      (dc_req),
        .dc_ready    (dc_ready),
        .br_taken    (br_taken),
        .load_use    (load_use),
        .pc_we       (pc_we),
        .if_id_we    (if_id_we),
        .if_id_zero  (if_id_zero),
        .id_ex_we    (id_ex_we),
        .id_ex_zero  (id_ex_zero),
        .ex_mem_we   (ex_mem_we),
        .ex_mem_zero (ex_mem_zero),
        .mem_wb_we   (mem_wb_we),
        .mem_wb_zero (mem_wb_zero),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]   ctrl;
        logic [W-1:0] stall;
        logic [W-1:0] flush;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    hz_state_t    m_state = RUN;
    logic [W-1:0] m_stall = '0;
    logic [W-1:0] m_flush = '0;

    // ctrl order: pc_we, if_id_we/zero, id_ex_we/zero, ex_mem_we/zero, mem_wb_we/zero
    localparam logic [8:0] C_RST  = 9'b0_00_00_00_00;
    localparam logic [8:0] C_DEF  = 9'b1_10_10_10_10;
    localparam logic [8:0] C_DS   = 9'b0_00_00_00_11;
    localparam logic [8:0] C_BR   = 9'b1_11_11_10_10;
    localparam logic [8:0] C_KILL = 9'b0_11_10_10_10;
    localparam logic [8:0] C_LU   = 9'b0_00_11_10_10;
    localparam logic [8:0] C_IS   = 9'b0_11_10_10_10;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == {W{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic predict();
        exp_t e;
        if (!rst) begin
            e = '0;
            m_state = RUN;
            m_stall = '0;
            m_flush = '0;
        end else begin
            e.stall = m_stall;
            e.flush = m_flush;
            if (dc_req && !dc_ready) begin
                e.ctrl = C_DS;
            end else if (br_taken) begin
                e.ctrl = C_BR;
                m_flush = sat_inc(m_flush);
                m_state = ic_ready ? RUN : I_KILL;
            end else if (m_state == I_KILL) begin
                e.ctrl = C_KILL;
                if (ic_ready) m_state = RUN;
            end else if (load_use) begin
                e.ctrl = C_LU;
            end else if (!ic_ready) begin
                e.ctrl = C_IS;
            end else begin
                e.ctrl = C_DEF;
            end
            if (!e.ctrl[8]) m_stall = sat_inc(m_stall);
        end
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_ctrl"}, {pc_we, if_id_we, if_id_zero, id_ex_we, id_ex_zero,
                              ex_mem_we, ex_mem_zero, mem_wb_we, mem_wb_zero}, e.ctrl);
        check({tag, "_stall_cnt"}, stall_cnt, e.stall);
        check({tag, "_flush_cnt"}, flush_cnt, e.flush);
    endtask

    task automatic step(input string tag, input logic r, input logic ic, input logic dq,
                        input logic dr, input logic br, input logic lu);
        @(posedge clk);
        #1;
        rst = r; ic_ready = ic; dc_req = dq; dc_ready = dr; br_taken = br; load_use = lu;
        predict();
        @(negedge clk);
        compare(tag);
    endtask

    initial begin
        rst = 1'b0; ic_ready = 1'b1; dc_req = 1'b0; dc_ready = 1'b0;
        br_taken = 1'b0; load_use = 1'b0;

        for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) step("dmiss_br", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("dmiss_done_br", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("after_br", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step("load_use", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("after_lu", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step("br_imiss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step("ikill_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ikill_ret", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("run_again", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step("lu_imiss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("imiss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("idle2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // enter I_KILL and stall long enough to saturate the 4-bit stall counter
        step("sat_br", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step("sat_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_saturated", stall_cnt, 15);

        // asynchronous reset between clock edges while stalled in I_KILL
        @(posedge clk);
        #3;
        rst = 1'b0;
        predict();
        #1;
        compare("async_rst");
        @(negedge clk);
        step("rst_release", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("run_after_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
